cpu_rf_wb_arb: RTL

- Writeback arbiter that drives the write port of the CPU register file (wrt_sel/wrt_data/wrt_en). It is the writer end of the RF interface.
- Merges two result sources: single-cycle ALU results, which have priority, and load/MMIO returns, which are buffered in a small FIFO.
- Keeps a per-register busy scoreboard of outstanding loads for hazard detection.
- Applies a starvation limit so that loads eventually drain under continuous ALU traffic.

---
 rtl/cpu_rf_wb_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cpu_rf_wb_arb.sv
// Writeback arbiter for the register-file write port: ALU results have priority; load returns queue in a FIFO with a starvation override.
// Optional macro WB_LD_BYPASS_EN lets a load skip an empty FIFO when the ALU is idle.
module cpu_rf_wb_arb #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_vld,
  input  logic [3:0]                 alu_rd,
  input  logic [31:0]                alu_data,
  output logic                       alu_stall,
  input  logic                       ld_vld,
  output logic                       ld_rdy,
  input  logic [3:0]                 ld_rd,
  input  logic [31:0]                ld_data,
  input  logic                       ld_iss,
  input  logic [3:0]                 ld_iss_rd,
  output logic                       wrt_en,
  output logic [3:0]                 wrt_sel,
  output logic [31:0]                wrt_data,
  output logic [15:0]                busy,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [AW:0]   DEPTH_CNT  = (AW + 1)'(DEPTH);

  logic [35:0]   mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [15:0]   busy_reg, busy_next;
  logic          wrt_en_reg, wrt_en_next;
  logic [3:0]    wrt_sel_reg;
  logic [31:0]   wrt_data_reg;
  logic          err_reg, err_next;

  logic          fifo_empty;
  logic          force_ld;
  logic          grant_alu;
  logic          pop;
  logic          byp;
  logic          push;
  logic          grant_ld;
  logic          any_grant;
  logic [3:0]    head_rd;
  logic [31:0]   head_data;
  logic [3:0]    sel_rd;
  logic [31:0]   sel_data;

  assign fifo_empty = (count_reg == '0);
  assign ld_rdy     = (count_reg < DEPTH_CNT);
  assign head_rd    = mem_reg[rd_ptr_reg][35:32];
  assign head_data  = mem_reg[rd_ptr_reg][31:0];

  // Starvation override beats the ALU; the ALU must then hold its result.
  assign force_ld  = (starve_reg == STARVE_MAX) && !fifo_empty;
  assign pop       = force_ld || (!alu_vld && !fifo_empty);
  assign grant_alu = alu_vld && !force_ld;
  assign alu_stall = alu_vld && force_ld;

`ifdef WB_LD_BYPASS_EN
  assign byp = fifo_empty && !alu_vld && ld_vld;
`else
  assign byp = 1'b0;
`endif

  assign push      = ld_vld && ld_rdy && !byp;
  assign grant_ld  = pop || byp;
  assign any_grant = grant_alu || grant_ld;

  always_comb begin
    sel_rd   = ld_rd;
    sel_data = ld_data;
    if (grant_alu) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (pop) begin
      sel_rd   = head_rd;
      sel_data = head_data;
    end
  end

  // R0 writes are dropped but still flagged when they carry non-zero data.
  always_comb begin
    wrt_en_next = any_grant && (sel_rd != 4'd0);
    err_next    = (any_grant && (sel_rd == 4'd0) && (sel_data != 32'd0))
               || (grant_alu && busy_reg[alu_rd]);
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + (AW + 1)'(1);
    else if (pop && !push)
      count_next = count_reg - (AW + 1)'(1);
  end

  always_comb begin
    starve_next = starve_reg;
    if (fifo_empty || pop)
      starve_next = '0;
    else if (starve_reg != STARVE_MAX)
      starve_next = starve_reg + SW'(1);
  end

  // Per-register scoreboard: a new issue wins over a same-cycle load retire.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_busy
      logic set_bit;
      logic clr_bit;
      assign set_bit = ld_iss && (ld_iss_rd == 4'(gi)) && (ld_iss_rd != 4'd0);
      assign clr_bit = grant_ld && (sel_rd == 4'(gi));
      assign busy_next[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : busy_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push)
      mem_reg[wr_ptr_reg] <= {ld_rd, ld_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      starve_reg   <= '0;
      busy_reg     <= '0;
      wrt_en_reg   <= 1'b0;
      wrt_sel_reg  <= 4'd0;
      wrt_data_reg <= 32'd0;
      err_reg      <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg  <= count_next;
      starve_reg <= starve_next;
      busy_reg   <= busy_next;
      wrt_en_reg <= wrt_en_next;
      err_reg    <= err_next;
      if (wrt_en_next) begin
        wrt_sel_reg  <= sel_rd;
        wrt_data_reg <= sel_data;
      end
    end
  end

  assign wrt_en   = wrt_en_reg;
  assign wrt_sel  = wrt_sel_reg;
  assign wrt_data = wrt_data_reg;
  assign busy     = busy_reg;
  assign fifo_cnt = count_reg;
  assign err      = err_reg;

endmodule
